// File: rtl/clk_divider_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The divisor clamp works on a wide word so any channel WIDTH up to 64 can use it.
package clk_divider_multi_pkg;

    localparam int MIN_DIV   = 2;
    localparam int DEF_WIDTH = 28;
    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] div_word_t;

    // Periods below two cycles cannot produce both a wrap and a distinct count.
    function automatic div_word_t clamp_div(input div_word_t d);
        return (d < div_word_t'(MIN_DIV)) ? div_word_t'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/shadow configuration,
// registered divided clock and per-period tick.
module clk_div_channel
    import clk_divider_multi_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50000000)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic [WIDTH-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV >> 1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] shadow_div;
    logic [WIDTH-1:0] shadow_high;
    logic             wrap;
    logic             load;

    assign wrap = (cnt == div_act - WIDTH'(1));
    // A stopped channel has no period to protect, so pending config lands at once.
    assign load = pending & (~en | wrap);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div_act     <= DEFAULT_DIV;
            high_act    <= DEFAULT_HIGH;
            shadow_div  <= DEFAULT_DIV;
            shadow_high <= DEFAULT_HIGH;
            pending     <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
        end else begin
            if (en) begin
                cnt     <= wrap ? '0 : cnt + WIDTH'(1);
                clk_out <= (cnt < high_act);
                tick    <= wrap;
            end else begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end

            if (load) begin
                div_act  <= shadow_div;
                high_act <= shadow_high;
            end

            // A write coinciding with a load re-arms pending for the next boundary.
            if (wr) begin
                shadow_div  <= WIDTH'(clamp_div(div_word_t'(wr_div)));
                shadow_high <= wr_high;
                pending     <= 1'b1;
            end else if (load) begin
                pending     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: decodes the shared config write
// port into per-channel strobes and replicates the channel datapath.
module clk_divider_multi
    import clk_divider_multi_pkg::*;
#(
    parameter int               CHANNELS    = 4,
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50000000),
    localparam int              CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic [WIDTH-1:0]    wr_high,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic [CHANNELS-1:0] wr_sel;

    // Out-of-range channel numbers match no lane and are silently dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) wr_sel[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (en[g]),
            .wr      (wr_sel[g]),
            .wr_div  (wr_div),
            .wr_high (wr_high),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: waveforms are captured as bit strings
// (first sample in the MSB) and compared against hand-derived patterns.
module tb_clk_divider_multi;

    localparam int W = 28;

    logic          clk_in;
    logic          rst_n;
    logic [3:0]    en;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [W-1:0]  wr_div;
    logic [W-1:0]  wr_high;
    logic [3:0]    clk_out;
    logic [3:0]    tick;
    logic [3:0]    pending;

    logic [4:0]    en2;
    logic          wr_en2;
    logic [2:0]    wr_ch2;
    logic [4:0]    clk_out2;
    logic [4:0]    tick2;
    logic [4:0]    pending2;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] cb, tb, pb;

    clk_divider_multi #(.CHANNELS(4), .WIDTH(W), .DEFAULT_DIV(W'(10))) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    // Five channels so that wr_ch can address a channel that does not exist.
    clk_divider_multi #(.CHANNELS(5), .WIDTH(W), .DEFAULT_DIV(W'(10))) dut5 (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en2),
        .wr_en   (wr_en2),
        .wr_ch   (wr_ch2),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .clk_out (clk_out2),
        .tick    (tick2),
        .pending (pending2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step n edges, sampling 1 ns after each; any write strobe lasts one edge.
    task automatic capture(input int ch, input int n,
                           output logic [31:0] c, output logic [31:0] t, output logic [31:0] p);
        c = '0; t = '0; p = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in); #1;
            wr_en = 1'b0;
            c = {c[30:0], clk_out[ch]};
            t = {t[30:0], tick[ch]};
            p = {p[30:0], pending[ch]};
        end
    endtask

    task automatic do_wr(input logic [1:0] ch, input int d, input int h);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = W'(d);
        wr_high = W'(h);
    endtask

    initial begin
        rst_n = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
        en2 = '0; wr_en2 = 1'b0; wr_ch2 = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_clk",     32'(clk_out), 32'h0);
        chk("rst_tick",    32'(tick),    32'h0);
        chk("rst_pend",    32'(pending), 32'h0);
        chk("rst_pend5",   32'(pending2), 32'h0);

        // 1: default divisor 10, half duty
        rst_n = 1'b1; en = 4'b0001;
        capture(0, 20, cb, tb, pb);
        chk("t1_clk",  cb, 32'b11111_00000_11111_00000);
        chk("t1_tick", tb, 32'b00000_00001_00000_00001);
        chk("t1_idle_clk",  32'(clk_out[3:1]), 32'h0);
        chk("t1_idle_tick", 32'(tick[3:1]),    32'h0);

        // 2: reprogram ch1 mid-period; old period must finish intact
        en[1] = 1'b1;
        capture(1, 3, cb, tb, pb);
        chk("t2a_clk",  cb, 32'b111);
        chk("t2a_pend", pb, 32'b000);
        do_wr(2'd1, 4, 1);
        capture(1, 15, cb, tb, pb);
        chk("t2b_clk",  cb, 32'b11000_00100_01000);
        chk("t2b_tick", tb, 32'b00000_01000_10001);
        chk("t2b_pend", pb, 32'b11111_10000_00000);
        chk("t2_ch0_pend", 32'(pending[0]), 32'h0);

        // 3: divisor 0 clamps to 2
        do_wr(2'd2, 0, 1);
        capture(2, 2, cb, tb, pb);
        chk("t3_pend_stopped", pb, 32'b10);
        en[2] = 1'b1;
        capture(2, 8, cb, tb, pb);
        chk("t3_clk",  cb, 32'b10101010);
        chk("t3_tick", tb, 32'b01010101);

        // 4: high=0 gives constant low, then high>div gives constant high
        do_wr(2'd3, 10, 0);
        capture(3, 2, cb, tb, pb);
        chk("t4_pend_stopped", pb, 32'b10);
        en[3] = 1'b1;
        capture(3, 20, cb, tb, pb);
        chk("t4a_clk",  cb, 32'h0);
        chk("t4a_tick", tb, 32'b00000_00001_00000_00001);
        do_wr(2'd3, 10, 12);
        capture(3, 20, cb, tb, pb);
        chk("t4b_clk",  cb, 32'b00000_00000_11111_11111);
        chk("t4b_tick", tb, 32'b00000_00001_00000_00001);
        chk("t4b_pend", pb, 32'b11111_11110_00000_00000);

        // 5: disable mid-period, reconfigure while stopped, restart
        en[0] = 1'b0;
        capture(0, 1, cb, tb, pb);
        chk("t5_stop_clk", cb, 32'b0);
        en[0] = 1'b1;
        capture(0, 6, cb, tb, pb);
        chk("t5a_clk", cb, 32'b111110);
        en[0] = 1'b0;
        do_wr(2'd0, 6, 3);
        capture(0, 3, cb, tb, pb);
        chk("t5b_clk",  cb, 32'b000);
        chk("t5b_tick", tb, 32'b000);
        chk("t5b_pend", pb, 32'b100);
        en[0] = 1'b1;
        capture(0, 12, cb, tb, pb);
        chk("t5c_clk",  cb, 32'b111000_111000);
        chk("t5c_tick", tb, 32'b000001_000001);
        chk("t5c_pend", pb, 32'b0);

        // 6: asynchronous reset mid-period drops outputs and pending writes
        do_wr(2'd3, 7, 2);
        capture(0, 1, cb, tb, pb);
        chk("t6_pre_clk0",  32'(clk_out[0]), 32'h1);
        chk("t6_pre_pend3", 32'(pending[3]), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_clk",  32'(clk_out), 32'h0);
        chk("t6_rst_tick", 32'(tick),    32'h0);
        chk("t6_rst_pend", 32'(pending), 32'h0);
        @(posedge clk_in); #1;
        rst_n = 1'b1; en = 4'b1000;
        capture(3, 20, cb, tb, pb);
        chk("t6_def_clk",  cb, 32'b11111_00000_11111_00000);
        chk("t6_def_tick", tb, 32'b00000_00001_00000_00001);
        chk("t6_def_pend", pb, 32'h0);

        // out-of-range channel writes on the 5-channel instance
        wr_div = W'(6); wr_high = W'(3);
        wr_en2 = 1'b1; wr_ch2 = 3'd5;
        @(posedge clk_in); #1;
        chk("t6_ch5_ignored", 32'(pending2), 32'h0);
        wr_ch2 = 3'd7;
        @(posedge clk_in); #1;
        chk("t6_ch7_ignored", 32'(pending2), 32'h0);
        wr_ch2 = 3'd4;
        @(posedge clk_in); #1;
        wr_en2 = 1'b0;
        chk("t6_ch4_written", 32'(pending2), 32'b10000);
        @(posedge clk_in); #1;
        chk("t6_ch4_loaded",  32'(pending2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
